// File: rtl/ula_md.sv
// ula_md: iterative RV32M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle,
// with single-cycle resolution of divide-by-zero and signed overflow.
// Optional build macro: ULA_MD_FAST_ZERO_EN (zero operands resolve in one cycle).
module ula_md #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data1_in,
  input  logic [WIDTH-1:0] data2_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             spec;
  logic [2:0]       op_q;
  logic             neg_res;

  // Shared datapath: acc_hi is the product high half or the partial remainder,
  // acc_lo is the multiplier/product low half or the dividend/quotient,
  // opb is the multiplicand or the divisor.
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opb;

  // Two's-complement negation when the sign flag is set.
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic signed [2*WIDTH-1:0] apply_sign2(input logic [2*WIDTH-1:0] v,
                                                            input logic n);
    return n ? $signed(-v) : $signed(v);
  endfunction

  // Launch decode
  logic             is_div;
  logic             sgn1, sgn2;
  logic             neg1, neg2;
  logic [WIDTH-1:0] mag1, mag2;
  logic             neg_launch;
  logic             div_zero, div_ovf, fast_zero;
  logic             spec_launch;
  logic [WIDTH-1:0] spec_res;
  logic             accept;

  assign is_div = op[2];
  assign sgn1   = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign sgn2   = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign neg1   = sgn1 & data1_in[WIDTH-1];
  assign neg2   = sgn2 & data2_in[WIDTH-1];
  assign mag1   = apply_sign(data1_in, neg1);
  assign mag2   = apply_sign(data2_in, neg2);

  // Remainder follows the dividend's sign; quotient and product follow sign1^sign2.
  assign neg_launch = (is_div && op[1]) ? neg1 : (neg1 ^ neg2);

  assign div_zero = is_div && (data2_in == '0);
  assign div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                    (data1_in == MIN_NEG) && (data2_in == '1);
`ifdef ULA_MD_FAST_ZERO_EN
  assign fast_zero = is_div ? ((data1_in == '0) && (data2_in != '0))
                            : ((data1_in == '0) || (data2_in == '0));
`else
  assign fast_zero = 1'b0;
`endif
  assign spec_launch = div_zero || div_ovf || fast_zero;

  // Result of a one-cycle special case (fast-zero falls through to 0).
  always_comb begin
    spec_res = '0;
    if (div_zero)
      spec_res = op[1] ? data1_in : '1;
    else if (div_ovf)
      spec_res = op[1] ? '0 : MIN_NEG;
  end

  assign accept = start && !flush && (state != S_CALC);

  // Iteration step values
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ge;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
  assign rem_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, opb};
  // Partial remainder stays below the divisor, so a set top bit means borrow.
  assign rem_ge    = ~rem_diff[WIDTH];

  // Final result selection with sign correction
  logic signed [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]          quo_s, rem_s;
  logic [WIDTH-1:0]          result;

  assign prod_s = apply_sign2({acc_hi, acc_lo}, neg_res);
  assign quo_s  = apply_sign(acc_lo, neg_res);
  assign rem_s  = apply_sign(acc_hi, neg_res);

  // Pick the requested half of the product, or quotient/remainder.
  always_comb begin
    result = '0;
    if (spec)
      result = acc_lo;
    else if (op_q[2])
      result = op_q[1] ? rem_s : quo_s;
    else if (op_q[1:0] == 2'd0)
      result = prod_s[WIDTH-1:0];
    else
      result = prod_s[2*WIDTH-1:WIDTH];
  end

  // Datapath: load magnitudes on launch, then one shift-add or restoring step per CALC cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_hi <= '0;
      if (spec_launch) begin
        acc_lo <= spec_res;
        opb    <= '0;
      end else if (is_div) begin
        acc_lo <= mag1;
        opb    <= mag2;
      end else begin
        acc_lo <= mag2;
        opb    <= mag1;
      end
    end else if (state == S_CALC && !spec && count != CNT_LAST) begin
      if (op_q[2]) begin
        acc_hi <= rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], rem_ge};
      end else begin
        acc_hi <= mul_sum[WIDTH:1];
        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
    end
  end

  // Control FSM with registered busy/done and the held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
      spec     <= 1'b0;
      op_q     <= '0;
      neg_res  <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_CALC: begin
          if (spec || count == CNT_LAST) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            data_out <= result;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
          if (start) begin
            state   <= S_CALC;
            busy    <= 1'b1;
            count   <= '0;
            spec    <= spec_launch;
            op_q    <= op;
            neg_res <= neg_launch;
          end
        end
      endcase
    end
  end

  assign zero = (data_out == '0);

endmodule

// File: tb/tb_ula_md.sv
// tb_ula_md: randomized and directed bench for ula_md against a 64-bit arithmetic model.
// Follows ULA_MD_FAST_ZERO_EN for the expected latency of zero-operand cases.
module tb_ula_md;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] data1_in;
  logic [31:0] data2_in;
  logic        busy;
  logic        done;
  logic [31:0] data_out;
  logic        zero;

  ula_md #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .flush    (flush),
    .op       (op),
    .data1_in (data1_in),
    .data2_in (data2_in),
    .busy     (busy),
    .done     (done),
    .data_out (data_out),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_res;
  int          exp_lat;
  logic [31:0] last_res;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V M semantics via 64-bit integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    int              ia;
    int              ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      3'd0: begin p = ua * ub;           return p[31:0];  end
      3'd1: begin p = sa * sb;           return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub;           return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_spec(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 32'd0) return 1'b1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
`ifdef ULA_MD_FAST_ZERO_EN
    if (!f[2] && (a == 32'd0 || b == 32'd0)) return 1'b1;
    if (f[2] && a == 32'd0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Present an operation for one edge, then scramble the inputs.
  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    op       = f;
    data1_in = a;
    data2_in = b;
    start    = 1'b1;
    exp_res  = model(f, a, b);
    exp_lat  = is_spec(f, a, b) ? 1 : 33;
    @(posedge clk); #1;
    start    = 1'b0;
    op       = 3'($urandom);
    data1_in = $urandom;
    data2_in = $urandom;
    if (exp_lat != 1) check_val("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int elapsed);
    int cyc;
    bit seen;
    cyc  = elapsed;
    seen = 1'b0;
    while (cyc < 60 && !seen) begin
      @(posedge clk); #1;
      cyc++;
      if (done) seen = 1'b1;
    end
    check_val({tag, "_lat"}, seen ? cyc : -1, exp_lat);
    check_val({tag, "_res"}, data_out, exp_res);
    check_val({tag, "_zero"}, 32'(zero), 32'(exp_res == 32'd0));
    last_res = exp_res;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    check_val("done_pulse_end", 32'(done), 32'd0);
    check_val("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b);
    launch(f, a, b);
    wait_done(tag, 0);
    idle_cycle();
  endtask

  initial begin
    bit seen;
    rst      = 1'b1;
    start    = 1'b0;
    flush    = 1'b0;
    op       = 3'd0;
    data1_in = 32'd0;
    data2_in = 32'd0;
    last_res = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_data", data_out, 32'd0);
    check_val("rst_zero", 32'(zero), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    run("mul_7_m3",   3'd0, 32'h0000_0007, 32'hFFFF_FFFD);
    run("mulh",       3'd1, 32'h8000_0000, 32'hFFFF_FFFF);
    run("mulhsu",     3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run("mulhu",      3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    run("div_m7_2",   3'd4, 32'hFFFF_FFF9, 32'h0000_0002);
    run("rem_m7_2",   3'd6, 32'hFFFF_FFF9, 32'h0000_0002);
    run("divu",       3'd5, 32'hFFFF_FFFF, 32'h0000_0010);
    run("divu_by0",   3'd5, 32'h1234_5678, 32'h0000_0000);
    run("rem_by0",    3'd6, 32'h0000_0005, 32'h0000_0000);
    run("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    // start pulse while busy must not disturb the running divide
    launch(3'd4, 32'd100, 32'd7);
    repeat (4) begin @(posedge clk); #1; end
    start    = 1'b1;
    op       = 3'd0;
    data1_in = $urandom;
    data2_in = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("start_in_busy", 5);
    idle_cycle();

    // flush in CALC cycle 10, with a competing start
    launch(3'd0, 32'd12345, 32'd6789);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    start = 1'b0;
    check_val("flush_busy", 32'(busy), 32'd0);
    check_val("flush_done", 32'(done), 32'd0);
    check_val("flush_data", data_out, last_res);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    check_val("flush_no_done", 32'(seen), 32'd0);
    check_val("flush_data_held", data_out, last_res);

    // asynchronous reset mid-calculation
    launch(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check_val("amid_rst_busy", 32'(busy), 32'd0);
    check_val("amid_rst_done", 32'(done), 32'd0);
    check_val("amid_rst_data", data_out, 32'd0);
    check_val("amid_rst_zero", 32'(zero), 32'd1);
    @(negedge clk);
    rst      = 1'b0;
    last_res = 32'd0;
    @(posedge clk); #1;

    // back-to-back: start held in the done cycle
    launch(3'd0, 32'd3, 32'd5);
    wait_done("b2b_a", 0);
    launch(3'd1, 32'hFFFF_FFFF, 32'd2);
    check_val("b2b_done_drop", 32'(done), 32'd0);
    wait_done("b2b_b", 0);
    idle_cycle();

    run("mul_zero", 3'd0, 32'd0, 32'h0000_1234);
    run("divu_zero_dividend", 3'd5, 32'd0, 32'd9);

    // randomized operations, mixing idle gaps and back-to-back launches
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      launch(f, a, b);
      wait_done("rnd", 0);
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
